fc_tx_tlp_arbiter: RTL
======================

Name: fc_tx_tlp_arbiter

Overview:
Shares the single TLP send port of the flow-control TX gating logic among three TLP sources: MWr (posted), MRd (non-posted) and Cpl (completion).
- Selects one pending source by round-robin, latches its TLP and holds the send request until the FC TX logic grants it or a timeout expires.
- Acknowledges the source on grant.
- Sits between the transaction-layer request queues and the FC TX controller's send_tlp_req/grant interface.

Parameters:
TIMEOUT, 64, max REQ cycles without grant before the arbiter abandons the request and rotates; 0 disables the timeout.
CNT_W, 16, width of the saturating timeout statistics counter.

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
req_valid_i  input  3  per-source TLP pending; bit0 = MWr, bit1 = MRd, bit2 = Cpl
req_size_i  input  24  per-source size in DW, 8 bits each; source i uses bits [8i+7:8i]
req_data_i  input  384  per-source TLP data, 128 bits each
req_ack_o  output  3  one-cycle accept pulse to the granted source
send_tlp_req_o  output  1  request to FC TX gating
send_tlp_type_o  output  2  2'b00 = MWr, 2'b01 = MRd, 2'b10 = Cpl
send_tlp_size_o  output  8  size of the latched TLP
send_tlp_data_o  output  128  data of the latched TLP
send_tlp_grant_i  input  1  FC TX has accepted the presented TLP
busy_o  output  1  high while in REQ
timeout_cnt_o  output  CNT_W  saturating count of abandoned requests

Behaviour:
- Reset (async, rst=1): state IDLE; rr_ptr=0; wait_cnt=0; all outputs 0 (type 2'b00, size 0, data 0, ack 0, timeout_cnt 0). A reset mid-REQ drops the pending TLP with no ack, so the source keeps valid and is re-arbitrated.
- Sources must hold valid, size and data stable until acked. The arbiter does not check this; the latched copy is used.
- IDLE:
  - If any req_valid_i bit is set, pick the first set bit scanning from rr_ptr upward, mod 3.
  - Latch sel, type=sel, size and data into output registers; clear wait_cnt; go to REQ.
  - send_tlp_req_o rises the cycle after valid is seen (1-cycle latency).
- REQ:
  - send_tlp_req_o=1; type, size and data are stable.
  - If send_tlp_grant_i=1: req_ack_o[sel]=1 combinationally in the same cycle; rr_ptr=(sel+1) mod 3; go to IDLE.
  - Else if TIMEOUT!=0 and wait_cnt==TIMEOUT-1: no ack; rr_ptr=(sel+1) mod 3; timeout_cnt_o += 1, saturating at all-ones; go to IDLE.
  - Else wait_cnt += 1.
- Grant and timeout in the same cycle: grant wins, no timeout count.
- Grant while in IDLE is ignored; req_ack_o stays 0.
- A source dropping valid during REQ is ignored; the latched TLP is still presented and acked on grant.
- MRd carries no payload: when sel=1, send_tlp_size_o and send_tlp_data_o are forced to 0 regardless of inputs.
- Best-case throughput is one TLP per 2 cycles (IDLE, then REQ granted in its first cycle).
- At most one req_ack_o bit is high per cycle, and only in a REQ cycle with grant.
- Fairness: with all three valid and immediate grants, service order rotates MWr, MRd, Cpl, MWr, and so on.
- rr_ptr advances only on exit from REQ, never in IDLE.

Test Plan:
- Only MWr valid, size 8, data 0xA5.., grant on first REQ cycle -> send_tlp_req_o high at cycle 1 with type 00, size 8; req_ack_o=3'b001 at cycle 1; busy_o low at cycle 2.
- All three valid continuously, grant tied high -> acks in order 001, 010, 100, 001 every 2 cycles; MRd beats show size 0 and data 0 even with req_size_i=0x20.
- Cpl valid, grant held low, TIMEOUT=4 -> request high for exactly 4 cycles, no ack, timeout_cnt_o=1; with MWr also valid, next selection is MWr (ptr wrapped past 2).
- TIMEOUT=4, grant asserted on the 4th REQ cycle -> ack issued, timeout_cnt_o stays 0.
- rst asserted during REQ (MRd pending), then released -> outputs 0 immediately, no ack, rr_ptr=0; MRd re-presented one cycle after release and acked on grant.
- CNT_W=2, repeated timeouts -> timeout_cnt_o saturates at 3 after the 3rd timeout and holds.

Source files
------------

// File: rtl/fc_tx_tlp_arbiter.sv
`default_nettype none
// ============================================================================
// Module : fc_tx_tlp_arbiter
// Round-robin arbiter sharing the FC TX send_tlp port among MWr, MRd and Cpl.
// Rev    : 1.0  initial release
// ============================================================================
module fc_tx_tlp_arbiter #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       req_valid_i,
    input  logic [23:0]      req_size_i,
    input  logic [383:0]     req_data_i,
    output logic [2:0]       req_ack_o,
    output logic             send_tlp_req_o,
    output logic [1:0]       send_tlp_type_o,
    output logic [7:0]       send_tlp_size_o,
    output logic [127:0]     send_tlp_data_o,
    input  logic             send_tlp_grant_i,
    output logic             busy_o,
    output logic [CNT_W-1:0] timeout_cnt_o
);

    localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [1:0]        rr_ptr;
    logic [WAIT_W-1:0] wait_cnt;
    logic [1:0]        pick;
    logic [1:0]        idx;
    logic              found;
    logic [7:0]        pick_size;
    logic [127:0]      pick_data;
    logic              load;
    logic              leave;
    logic              expire;
    logic              wait_done;

    function automatic logic [1:0] inc3(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    // First pending source scanning upward from rr_ptr, wrapping after Cpl
    always_comb begin
        pick  = rr_ptr;
        found = 1'b0;
        idx   = rr_ptr;
        for (int k = 0; k < 3; k++) begin
            if (!found && req_valid_i[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
            idx = inc3(idx);
        end
    end

    // MRd has no payload, so its size and data are presented as zero
    always_comb begin
        pick_size = 8'd0;
        pick_data = 128'd0;
        case (pick)
            2'd0: begin
                pick_size = req_size_i[7:0];
                pick_data = req_data_i[127:0];
            end
            2'd2: begin
                pick_size = req_size_i[23:16];
                pick_data = req_data_i[383:256];
            end
            default: begin
                pick_size = 8'd0;
                pick_data = 128'd0;
            end
        endcase
    end

    assign wait_done = (TIMEOUT != 0) && (wait_cnt == WAIT_W'(TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        req_ack_o = 3'b000;
        load      = 1'b0;
        leave     = 1'b0;
        expire    = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    load      = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (send_tlp_grant_i) begin
                    req_ack_o = 3'b001 << send_tlp_type_o;
                    leave     = 1'b1;
                    state_nxt = IDLE;
                end else if (wait_done) begin
                    leave     = 1'b1;
                    expire    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr          <= 2'd0;
            wait_cnt        <= '0;
            send_tlp_type_o <= 2'b00;
            send_tlp_size_o <= 8'd0;
            send_tlp_data_o <= 128'd0;
            timeout_cnt_o   <= '0;
        end else begin
            if (load) begin
                send_tlp_type_o <= pick;
                send_tlp_size_o <= pick_size;
                send_tlp_data_o <= pick_data;
                wait_cnt        <= '0;
            end else if (state == REQ && !leave) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (leave) begin
                rr_ptr <= inc3(send_tlp_type_o);
            end
            if (expire && (timeout_cnt_o != {CNT_W{1'b1}})) begin
                timeout_cnt_o <= timeout_cnt_o + 1'b1;
            end
        end
    end

    assign send_tlp_req_o = (state == REQ);
    assign busy_o         = (state == REQ);

endmodule
`default_nettype wire
